// File: rtl/pc_unit_if.sv
// Control/status bundle between the control FSM (master) and pc_unit (slave).
// Carries the action enables, jump/branch operands, the program counter and
// the return-stack status. pc_wrap is present only when PC_WRAP_FLAG_EN is
// defined.
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SP_W   = 3
);
  logic              hold;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic              inc_en;
  logic              rel_en;
  logic [ADDR_W-1:0] rel_off;
  logic              call_en;
  logic              ret_en;
  logic [ADDR_W-1:0] pc_out;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;
`ifdef PC_WRAP_FLAG_EN
  logic              pc_wrap;
`endif

  modport master (
    output hold, load_en, load_addr, inc_en, rel_en, rel_off, call_en, ret_en,
    input  pc_out, sp, stack_full, stack_empty, stack_err
`ifdef PC_WRAP_FLAG_EN
    , input pc_wrap
`endif
  );

  modport slave (
    input  hold, load_en, load_addr, inc_en, rel_en, rel_off, call_en, ret_en,
    output pc_out, sp, stack_full, stack_empty, stack_err
`ifdef PC_WRAP_FLAG_EN
    , output pc_wrap
`endif
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit with signed relative branch and a call/return stack.
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - pc_unit_if.slave: enables/operands in, pc_out/sp/stack flags out
// One action per cycle, priority rst > hold > ret > call > load > rel > inc.
// Optional macro PC_WRAP_FLAG_EN adds the registered pc_wrap pulse.
module pc_unit #(
  parameter int unsigned              ADDR_W      = 8,
  parameter int unsigned              STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]        RESET_VEC   = '0
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);
  localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SLOTS  = 2 ** IDX_W;

  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [SP_W-1:0]   sp_q, sp_n;
  logic              err_q, err_n;
  logic              push_en;
  logic              sel_inc;
  logic              sel_rel;
  logic [ADDR_W-1:0] stack_mem [SLOTS];
  logic [ADDR_W-1:0] ret_addr;

  // Return address currently on top of the stack (only used when sp > 0).
  assign ret_addr = stack_mem[IDX_W'(sp_q - 1'b1)];

  // Next-state selection; hold suppresses every action including error setting.
  always_comb begin
    pc_n    = pc_q;
    sp_n    = sp_q;
    err_n   = err_q;
    push_en = 1'b0;
    sel_inc = 1'b0;
    sel_rel = 1'b0;
    if (!bus.hold) begin
      if (bus.ret_en) begin
        if (sp_q != '0) begin
          pc_n = ret_addr;
          sp_n = sp_q - 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end else if (bus.call_en) begin
        if (sp_q != SP_W'(STACK_DEPTH)) begin
          push_en = 1'b1;
          sp_n    = sp_q + 1'b1;
          pc_n    = bus.load_addr;
        end else begin
          err_n = 1'b1;
        end
      end else if (bus.load_en) begin
        pc_n = bus.load_addr;
      end else if (bus.rel_en) begin
        sel_rel = 1'b1;
        pc_n    = pc_q + bus.rel_off;
      end else if (bus.inc_en) begin
        sel_inc = 1'b1;
        pc_n    = pc_q + 1'b1;
      end
    end
  end

  // Architectural state; reset discards any operation requested in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_n;
      sp_q  <= sp_n;
      err_q <= err_n;
    end
  end

  // Return-address storage; contents need no reset since sp gates every read.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_mem[IDX_W'(sp_q)] <= pc_q + 1'b1;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_err   = err_q;
  assign bus.stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign bus.stack_empty = (sp_q == '0);

`ifdef PC_WRAP_FLAG_EN
  logic [ADDR_W:0] inc_sum;
  logic [ADDR_W:0] rel_sum;
  logic            wrap_n;
  logic            wrap_q;

  // Carry out of the widened sum; for a negative offset a missing carry is a borrow.
  always_comb begin
    inc_sum = {1'b0, pc_q} + (ADDR_W + 1)'(1);
    rel_sum = {1'b0, pc_q} + {1'b0, bus.rel_off};
    wrap_n  = 1'b0;
    if (sel_rel) begin
      wrap_n = bus.rel_off[ADDR_W-1] ? ~rel_sum[ADDR_W] : rel_sum[ADDR_W];
    end else if (sel_inc) begin
      wrap_n = inc_sum[ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_n;
    end
  end

  assign bus.pc_wrap = wrap_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the stimulus process runs a queue-based
// reference model and pushes the expected post-edge state; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_pc_unit;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] RESET_VEC = 8'h00;
  localparam int MOD = 1 << ADDR_W;

  typedef struct {
    int          step;
    logic [ADDR_W-1:0] pc;
    int          sp;
    logic        full;
    logic        empty;
    logic        err;
    logic        wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   step_no;
  exp_t exp_q [$];

  // Reference model state.
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_stk [$];
  logic              m_err;
  logic              m_wrap;

  pc_unit_if #(.ADDR_W(ADDR_W), .SP_W(SP_W)) bus ();

  pc_unit #(
    .ADDR_W(ADDR_W),
    .STACK_DEPTH(STACK_DEPTH),
    .RESET_VEC(RESET_VEC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, int stp, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, stp, act, expv);
    end
  endfunction

  // Monitor: pc_unit presents state every cycle, so one expectation per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_out", e.step, 32'(bus.pc_out), 32'(e.pc));
      check("sp", e.step, 32'(bus.sp), 32'(e.sp));
      check("stack_full", e.step, 32'(bus.stack_full), 32'(e.full));
      check("stack_empty", e.step, 32'(bus.stack_empty), 32'(e.empty));
      check("stack_err", e.step, 32'(bus.stack_err), 32'(e.err));
`ifdef PC_WRAP_FLAG_EN
      check("pc_wrap", e.step, 32'(bus.pc_wrap), 32'(e.wrap));
`endif
    end
  end

  // One clock of stimulus: drive, advance the model, then queue the expectation.
  task automatic step(input logic r, input logic h, input logic ld,
                      input logic [ADDR_W-1:0] la, input logic inc,
                      input logic rel, input logic [ADDR_W-1:0] ro,
                      input logic call, input logic ret);
    int   t;
    int   off;
    exp_t e;
    rst           = r;
    bus.hold      = h;
    bus.load_en   = ld;
    bus.load_addr = la;
    bus.inc_en    = inc;
    bus.rel_en    = rel;
    bus.rel_off   = ro;
    bus.call_en   = call;
    bus.ret_en    = ret;

    m_wrap = 1'b0;
    if (r) begin
      m_pc  = RESET_VEC;
      m_stk.delete();
      m_err = 1'b0;
    end else if (h) begin
      // nothing happens
    end else if (ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (call) begin
      if (m_stk.size() < STACK_DEPTH) begin
        m_stk.push_back(ADDR_W'((int'(m_pc) + 1) % MOD));
        m_pc = la;
      end else begin
        m_err = 1'b1;
      end
    end else if (ld) begin
      m_pc = la;
    end else if (rel) begin
      off = ro[ADDR_W-1] ? int'(ro) - MOD : int'(ro);
      t   = int'(m_pc) + off;
      m_wrap = (t < 0) || (t >= MOD);
      m_pc = ADDR_W'((t + MOD) % MOD);
    end else if (inc) begin
      t = int'(m_pc) + 1;
      m_wrap = (t >= MOD);
      m_pc = ADDR_W'(t % MOD);
    end

    e.step  = step_no;
    e.pc    = m_pc;
    e.sp    = m_stk.size();
    e.full  = (m_stk.size() == STACK_DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    e.wrap  = m_wrap;
    @(posedge clk);
    exp_q.push_back(e);
    step_no++;
    #1;
  endtask

  task automatic do_rst();  step(1, 0, 0, '0, 0, 0, '0, 0, 0); endtask
  task automatic do_inc();  step(0, 0, 0, '0, 1, 0, '0, 0, 0); endtask
  task automatic do_load(input logic [ADDR_W-1:0] a); step(0, 0, 1, a, 0, 0, '0, 0, 0); endtask
  task automatic do_rel(input logic [ADDR_W-1:0] o);  step(0, 0, 0, '0, 0, 1, o, 0, 0); endtask
  task automatic do_call(input logic [ADDR_W-1:0] a); step(0, 0, 0, a, 0, 0, '0, 1, 0); endtask
  task automatic do_ret();  step(0, 0, 0, '0, 0, 0, '0, 0, 1); endtask

  initial begin
    int budget;
    n_tests = 0;
    n_fail  = 0;
    step_no = 0;
    m_pc  = '0;
    m_err = 1'b0;
    m_wrap = 1'b0;

    // Reset then increment.
    do_rst();
    repeat (3) do_inc();
    // Relative branches, second one wraps below zero.
    do_load(8'h05);
    do_rel(8'hFB);
    do_rel(8'hFF);
    // Increment wrap from all-ones.
    do_load(8'hFF);
    do_inc();
    // Nested calls and returns.
    do_load(8'h10);
    do_call(8'h40);
    do_call(8'h80);
    do_ret();
    do_ret();
    // Overflow on the fifth call, then unwind; the push at 0xFF wraps to 0x00.
    do_load(8'hFF);
    do_call(8'h20);
    do_call(8'h30);
    do_call(8'h40);
    do_call(8'h50);
    do_call(8'h60);
    repeat (4) do_ret();
    // Underflow, then ret+call+inc together with one entry.
    do_rst();
    do_ret();
    do_call(8'h20);
    step(0, 0, 0, 8'h77, 1, 0, '0, 1, 1);
    // Hold blocks a call; reset wins over a call at sp = 2.
    do_call(8'h30);
    step(0, 1, 0, 8'h90, 0, 0, '0, 1, 0);
    do_call(8'hA0);
    step(1, 0, 0, 8'hB0, 0, 0, '0, 1, 0);
    // Hold also blocks an underflow error.
    step(0, 1, 0, '0, 0, 0, '0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0),
           ADDR_W'($urandom),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0),
           ADDR_W'($urandom),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the 8-bit program register.
- Adds width generalisation, a configurable reset vector, a signed relative branch and a hardware call/return stack with configurable depth.
- Sits between the control FSM and the address bus.
- `pc_out` drives instruction fetch addressing every cycle.

Parameters:
- ADDR_W, 8, width of PC, load address and relative offset.
- STACK_DEPTH, 4, number of return-address entries; legal range 1..16.
- RESET_VEC, 0, value loaded into PC on reset; must fit in ADDR_W bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  freeze: PC and stack unchanged this cycle.
- load_en  input  1  absolute jump: PC <= load_addr.
- load_addr  input  ADDR_W  jump or call target.
- inc_en  input  1  PC <= PC + 1.
- rel_en  input  1  PC <= PC + sign-extended rel_off.
- rel_off  input  ADDR_W  two's-complement relative offset.
- call_en  input  1  push PC+1, then PC <= load_addr.
- ret_en  input  1  PC <= top of stack, pop.
- pc_out  output  ADDR_W  current program counter (registered).
- sp  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == STACK_DEPTH (combinational from sp).
- stack_empty  output  1  sp == 0 (combinational from sp).
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-high on `rst`, sampled at the rising edge of `clk`.
- Reset values:
  - pc_out = RESET_VEC, sp = 0, stack_err = 0.
  - stack_empty = 1, stack_full = 0.
  - Stack contents are don't-care.
- Reset takes priority over every other input in the same cycle.
  - A reset during a call or return discards that operation.
- Per-cycle priority is rst > hold > ret_en > call_en > load_en > rel_en > inc_en.
  - Exactly one action is taken per cycle.
  - If no enable is set, PC holds.
- Latency: every action is visible on pc_out one cycle after the enabling edge. No combinational path from inputs to pc_out.
- Arithmetic wraps modulo 2^ADDR_W:
  - inc from all-ones gives 0.
  - Relative branch wraps in both directions.
  - The pushed return address PC+1 also wraps.
- call_en with sp < STACK_DEPTH:
  - stack[sp] <= pc_out + 1.
  - sp <= sp + 1.
  - pc_out <= load_addr.
- call_en with sp == STACK_DEPTH (overflow):
  - No push and no jump; PC holds.
  - stack_err <= 1.
- ret_en with sp > 0:
  - pc_out <= stack[sp-1].
  - sp <= sp - 1.
- ret_en with sp == 0 (underflow):
  - PC holds, sp stays 0.
  - stack_err <= 1.
- ret_en and call_en in the same cycle: ret_en wins; call_en is ignored with no error.
- stack_err is sticky and is cleared only by rst.
- hold = 1 blocks every action, including overflow and underflow error setting.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- When defined:
  - Adds output `pc_wrap` (1 bit, registered, reset 0).
  - pc_wrap pulses high for exactly one cycle after any inc or rel action whose result wrapped past 0 or past all-ones.
  - Wrap is detected from the carry/borrow of the ADDR_W+1-bit sum.
  - call, ret and load never assert it.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset and increment, defaults:
  - Stimulus: rst for 1 cycle, then inc_en for 3 cycles.
  - Response: pc_out = 0x00 after reset, then 0x01, 0x02, 0x03; sp = 0, stack_empty = 1.
- Relative branch with wrap:
  - Stimulus: load 0x05; then rel_off = 0xFB (-5); then rel_off = 0xFF.
  - Response: pc_out = 0x00, then 0xFF.
  - With PC_WRAP_FLAG_EN: pc_wrap = 0 for the first branch and 1 for the second.
- Nested calls and returns:
  - Stimulus: PC = 0x10; call to 0x40; call to 0x80; ret; ret.
  - Response: pc_out = 0x40, 0x80, 0x41, 0x11; sp = 1, 2, 1, 0.
- Overflow (STACK_DEPTH = 4):
  - Stimulus: 5 consecutive calls.
  - Response: the 5th leaves PC unchanged; sp = 4, stack_full = 1, stack_err = 1.
  - Following 4 rets return correctly; stack_err stays 1.
- Underflow and priority:
  - Stimulus: ret with sp = 0; then ret_en, call_en and inc_en asserted together with sp = 1.
  - Response: the first gives PC unchanged and stack_err = 1; the second performs a ret only.
- Hold and reset mid-operation:
  - Stimulus: hold = 1 with call_en; then rst together with call_en at sp = 2.
  - Response: the first changes nothing; the second gives pc_out = RESET_VEC, sp = 0, stack_err = 0.
